// File: rtl/ro_cfg_pkg.sv
// ro_cfg_pkg: shared state encoding and default geometry for the ring-oscillator config loader
package ro_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  localparam int DEF_CFG_W = 12;
  localparam int DEF_CLK_DIV = 4;
endpackage

// File: rtl/ro_cfg_loader_sync2.sv
// sync2: generic two-flop synchronizer for signals asynchronous to clk
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/ro_cfg_loader.sv
// ro_cfg_loader: serializes a config word MSB-first onto the macro chain, then re-shifts it to check the tail
module ro_cfg_loader
  import ro_cfg_pkg::*;
#(
  parameter int CFG_W   = DEF_CFG_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int VERIFY  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CFG_W-1:0]           cfg_data,
  input  logic                       chain_tail,
  output logic                       shift_clk,
  output logic                       shift_dta,
  output logic                       busy,
  output logic                       done,
  output logic                       match,
  output logic [$clog2(CFG_W+1)-1:0] mismatch_cnt
);
  localparam int HC_W  = $clog2(CLK_DIV);
  localparam int BC_W  = $clog2(CFG_W);
  localparam int CNT_W = $clog2(CFG_W+1);
  state_t           state;
  logic [HC_W-1:0]  hc;
  logic [BC_W-1:0]  bc;
  logic [CFG_W-1:0] rot;
  logic             tail_s;
  logic             half_end;
  logic             last_bit;
  logic [CNT_W-1:0] cnt_nxt;
  sync2 #(.W(1)) u_sync (.clk(clk), .rst_n(rst_n), .d(chain_tail), .q(tail_s));
  assign shift_dta = rot[CFG_W-1];
  always_comb begin
    half_end = hc == HC_W'(CLK_DIV-1);
    last_bit = bc == BC_W'(CFG_W-1);
    cnt_nxt  = (tail_s != rot[CFG_W-1] && mismatch_cnt != CNT_W'(CFG_W)) ? mismatch_cnt + 1'b1 : mismatch_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      hc           <= '0;
      bc           <= '0;
      rot          <= '0;
      shift_clk    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= LOAD;
          rot          <= cfg_data;
          hc           <= '0;
          bc           <= '0;
          busy         <= 1'b1;
          match        <= 1'b0;
          mismatch_cnt <= '0;
        end
        LOAD, ro_cfg_pkg::VERIFY: begin
          hc <= half_end ? '0 : hc + 1'b1;
          // rising half: sample the tail against the bit currently on the wire
          if (half_end && !shift_clk) begin
            shift_clk <= 1'b1;
            if (state == ro_cfg_pkg::VERIFY) mismatch_cnt <= cnt_nxt;
          end else if (half_end) begin
            shift_clk <= 1'b0;
            rot       <= {rot[CFG_W-2:0], rot[CFG_W-1]};
            bc        <= last_bit ? '0 : bc + 1'b1;
            if (last_bit) begin
              if (state == LOAD && VERIFY != 0) state <= ro_cfg_pkg::VERIFY;
              else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                match <= (VERIFY == 0) || (mismatch_cnt == '0);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ro_cfg_loader.sv
// tb_ro_cfg_loader: cycle-level reference model plus directed and random runs of the config loader
module tb_ro_cfg_loader;
  localparam int W = 12, D = 4, P = 2, END_N = 1 + P * W * 2 * D;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] cfg_data = '0;
  logic chain_tail, shift_clk, shift_dta, busy, done, match;
  logic [3:0] mismatch_cnt;
  logic start2 = 0;
  logic [W-1:0] cfg2 = '0;
  logic tail2, sclk2, sdta2, busy2, done2, match2;
  logic [3:0] cnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ro_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .chain_tail(chain_tail),
    .shift_clk(shift_clk), .shift_dta(shift_dta), .busy(busy), .done(done), .match(match),
    .mismatch_cnt(mismatch_cnt)
  );
  ro_cfg_loader #(.CFG_W(W), .CLK_DIV(2), .VERIFY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_data(cfg2), .chain_tail(tail2),
    .shift_clk(sclk2), .shift_dta(sdta2), .busy(busy2), .done(done2), .match(match2),
    .mismatch_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // target chain models: plain shift registers clocked by shift_clk
  logic [W-1:0] chain = '0, chain2 = '0, snap12 = '0, snap24 = '0;
  int rises = 0, rises2 = 0, mode = 0;
  always @(posedge shift_clk) begin
    chain = {chain[W-2:0], shift_dta};
    rises++;
    if (rises == 12) snap12 = chain;
    if (rises == 24) snap24 = chain;
  end
  always @(posedge sclk2) begin
    chain2 = {chain2[W-2:0], sdta2};
    rises2++;
  end
  assign chain_tail = mode == 0 ? chain[W-1] : (mode == 2);
  assign tail2 = chain2[W-1];

  // reference model: remembers acceptance cycle, derives outputs from elapsed cycles
  int cyc = 0, t0 = -1, mode_m = 0;
  logic [W-1:0] cfg_m = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t0 = -1;
      cfg_m = '0;
    end else begin
      if ((t0 < 0 || cyc - t0 > END_N) && start) begin
        t0 = cyc;
        cfg_m = cfg_data;
        mode_m = mode;
      end
      cyc++;
    end

  function automatic logic sent(input int k);
    return cfg_m[W-1-(k % W)];
  endfunction
  function automatic logic tail_bit(input int k);
    return mode_m == 0 ? sent(k) : (mode_m == 2);
  endfunction
  function automatic int exp_cnt(input int n);
    int c = 0;
    for (int k = 0; k < W; k++)
      if (n >= 1 + (W + k) * 2 * D + D && sent(k) != tail_bit(k)) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    int n, e_cnt;
    logic e_sclk, e_sdta, e_busy, e_done, e_match;
    n = t0 < 0 ? -1 : cyc - t0;
    {e_sclk, e_sdta, e_busy, e_done, e_match} = '0;
    e_cnt = 0;
    if (n >= 1 && n < END_N) begin
      e_busy = 1'b1;
      e_sclk = ((n - 1) % (2 * D)) >= D;
      e_sdta = sent((n - 1) / (2 * D));
      e_cnt  = exp_cnt(n);
    end else if (n >= END_N) begin
      e_done  = n == END_N;
      e_sdta  = cfg_m[W-1];
      e_cnt   = exp_cnt(n);
      e_match = e_cnt == 0;
    end
    chk("shift_clk", shift_clk, e_sclk);
    chk("shift_dta", shift_dta, e_sdta);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("match", match, e_match);
    chk("mismatch_cnt", mismatch_cnt, e_cnt);
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input logic [W-1:0] c, input int md, output int lat);
    @(negedge clk);
    cfg_data = c;
    mode = md;
    rises = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (3) begin
      @(negedge clk); start = 1; cfg_data = 12'hFFF;
      @(negedge clk); start = 0;
    end
    chk("rst_rises", rises, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dta", shift_dta, 0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    run(12'hA5C, 0, lat);
    chk("a5c_lat", lat, 193);
    chk("a5c_chain12", snap12, 12'hA5C);
    chk("a5c_chain24", snap24, 12'hA5C);
    chk("a5c_match", match, 1);
    chk("a5c_cnt", mismatch_cnt, 0);

    run(12'hFFF, 1, lat);
    chk("brk_fff_match", match, 0);
    chk("brk_fff_cnt", mismatch_cnt, 12);
    run(12'h000, 1, lat);
    chk("brk_000_match", match, 1);
    chk("brk_000_cnt", mismatch_cnt, 0);

    // start pulsed mid-run and in the DONE cycle are both ignored
    @(negedge clk); cfg_data = 12'h5A3; mode = 0; rises = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    start = 1; cfg_data = 12'hFFF;
    @(negedge clk); start = 0;
    wait_done(lat);
    start = 1;
    @(negedge clk); start = 0;
    chk("hs_idle_after_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("hs_still_idle", busy, 0);
    chk("hs_rises", rises, 24);
    chk("hs_match", match, 1);

    // start held through DONE is taken the cycle after
    @(negedge clk); cfg_data = 12'h6B1; start = 1;
    wait_done(lat);
    @(negedge clk);
    @(negedge clk); start = 0;
    chk("held_busy", busy, 1);
    lat = 1;
    wait_done(lat);
    chk("held_lat", lat, 193);

    // reset at t0+50
    @(negedge clk); cfg_data = 12'h9E7; mode = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (49) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sclk", shift_clk, 0);
    chk("mid_rst_dta", shift_dta, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run(12'h3C3, 0, lat);
    chk("post_rst_lat", lat, 193);
    chk("post_rst_match", match, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_data = W'($urandom);
      mode = $urandom_range(0, 2);
      start = 1;
      @(negedge clk);
      start = 0;
      lat = 1;
      while (!done && lat < 1000) begin
        @(negedge clk);
        lat++;
        if (!done) start = $urandom_range(0, 15) == 0;
      end
      start = 0;
      chk("rnd_lat", lat, 193);
    end

    @(negedge clk); cfg2 = 12'h801; rises2 = 0; start2 = 1;
    @(negedge clk); start2 = 0;
    lat = 1;
    while (!done2 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("nv_lat", lat, 49);
    chk("nv_rises", rises2, 12);
    chk("nv_chain", chain2, 12'h801);
    chk("nv_match", match2, 1);
    chk("nv_cnt", cnt2, 0);
    chk("nv_busy", busy2, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
